// File: rtl/layer_pkg.sv
// Shared constants and FSM encoding for the layer-to-layer feature map transfer.
// Transfer latency and flow control are documented in layer_xfer_ctrl.
package layer_pkg;

    localparam int DATA_SIZE = 64;
    localparam int IDX_W     = 16;

    // Default layer geometry: a 16-channel 26x26 feature map.
    localparam int L1_NUM_CH = 16;
    localparam int L1_DIM    = 26;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/idx_counter3d.sv
// Wrapping ch/row/col index counter (col fastest); updates one cycle after inc or clr.
// No backpressure of its own: the caller holds inc low to freeze the index.
module idx_counter3d
#(
    parameter int NUM_CH = 16,
    parameter int DIM    = 26,
    parameter int IDX_W  = 16
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [IDX_W-1:0] ch,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);
    import layer_pkg::*;

    localparam logic [IDX_W-1:0] CH_MAX  = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] DIM_MAX = IDX_W'(DIM - 1);

    logic [IDX_W-1:0] ch_q, ch_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;

    always_comb begin
        ch_d  = ch_q;
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            ch_d  = '0;
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_q == DIM_MAX) begin
                col_d = '0;
                if (row_q == DIM_MAX) begin
                    row_d = '0;
                    ch_d  = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ch_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            ch_q  <= ch_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign ch   = ch_q;
    assign row  = row_q;
    assign col  = col_q;
    assign last = (ch_q == CH_MAX) && (row_q == DIM_MAX) && (col_q == DIM_MAX);

endmodule

// File: rtl/layer_xfer_ctrl.sv
// Copies a NUM_CH x DIM x DIM map from layer output to next-layer input; write appears 2 cycles after read issue.
// dst_ready low freezes both pipeline stages and the read index; done/next_start pulse one cycle after the last write.
module layer_xfer_ctrl
#(
    parameter int NUM_CH    = layer_pkg::L1_NUM_CH,
    parameter int DIM       = layer_pkg::L1_DIM,
    parameter int IDX_W     = layer_pkg::IDX_W,
    parameter int DATA_SIZE = layer_pkg::DATA_SIZE
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 next_start,
    output logic                 src_rd_en,
    output logic [IDX_W-1:0]     src_ch,
    output logic [IDX_W-1:0]     src_row,
    output logic [IDX_W-1:0]     src_col,
    input  logic [DATA_SIZE-1:0] src_rd_data,
    output logic                 dst_wr_en,
    output logic [IDX_W-1:0]     dst_ch,
    output logic [IDX_W-1:0]     dst_row,
    output logic [IDX_W-1:0]     dst_col,
    output logic [DATA_SIZE-1:0] dst_wr_data,
    input  logic                 dst_ready
);
    import layer_pkg::*;

    xfer_state_e state_q, state_d;

    logic cnt_last, cnt_clr, stall, last_accept;

    // P1: read in flight, waiting for src_rd_data
    logic             p1_vld_q, p1_vld_d, p1_last_q, p1_last_d;
    logic [IDX_W-1:0] p1_ch_q, p1_ch_d, p1_row_q, p1_row_d, p1_col_q, p1_col_d;

    // Output stage
    logic                 dst_vld_q, dst_vld_d, dst_last_q, dst_last_d;
    logic [IDX_W-1:0]     dst_ch_q, dst_ch_d, dst_row_q, dst_row_d, dst_col_q, dst_col_d;
    logic [DATA_SIZE-1:0] dst_dat_q, dst_dat_d;

    assign stall       = dst_vld_q && !dst_ready;
    assign src_rd_en   = (state_q == ST_READ) && !stall;
    assign cnt_clr     = (state_q == ST_FINISH);
    assign last_accept = dst_vld_q && dst_ready && dst_last_q;

    idx_counter3d #(
        .NUM_CH (NUM_CH),
        .DIM    (DIM),
        .IDX_W  (IDX_W)
    ) u_rd_idx (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (src_rd_en),
        .clr     (cnt_clr),
        .ch      (src_ch),
        .row     (src_row),
        .col     (src_col),
        .last    (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;
        next_start = 1'b0;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_READ;
            ST_READ:   if (src_rd_en && cnt_last) state_d = ST_DRAIN;
            ST_DRAIN:  if (last_accept) state_d = ST_FINISH;
            ST_FINISH: begin
                done       = 1'b1;
                next_start = 1'b1;
                state_d    = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        p1_vld_d   = p1_vld_q;
        p1_last_d  = p1_last_q;
        p1_ch_d    = p1_ch_q;
        p1_row_d   = p1_row_q;
        p1_col_d   = p1_col_q;
        dst_vld_d  = dst_vld_q;
        dst_last_d = dst_last_q;
        dst_ch_d   = dst_ch_q;
        dst_row_d  = dst_row_q;
        dst_col_d  = dst_col_q;
        dst_dat_d  = dst_dat_q;
        if (state_q == ST_FINISH) begin
            p1_vld_d   = 1'b0;
            p1_last_d  = 1'b0;
            p1_ch_d    = '0;
            p1_row_d   = '0;
            p1_col_d   = '0;
            dst_vld_d  = 1'b0;
            dst_last_d = 1'b0;
            dst_ch_d   = '0;
            dst_row_d  = '0;
            dst_col_d  = '0;
            dst_dat_d  = '0;
        end else if (!stall) begin
            p1_vld_d   = src_rd_en;
            p1_last_d  = src_rd_en && cnt_last;
            p1_ch_d    = src_ch;
            p1_row_d   = src_row;
            p1_col_d   = src_col;
            dst_vld_d  = p1_vld_q;
            dst_last_d = p1_last_q;
            dst_ch_d   = p1_ch_q;
            dst_row_d  = p1_row_q;
            dst_col_d  = p1_col_q;
            dst_dat_d  = src_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            p1_vld_q   <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_ch_q    <= '0;
            p1_row_q   <= '0;
            p1_col_q   <= '0;
            dst_vld_q  <= 1'b0;
            dst_last_q <= 1'b0;
            dst_ch_q   <= '0;
            dst_row_q  <= '0;
            dst_col_q  <= '0;
            dst_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            p1_vld_q   <= p1_vld_d;
            p1_last_q  <= p1_last_d;
            p1_ch_q    <= p1_ch_d;
            p1_row_q   <= p1_row_d;
            p1_col_q   <= p1_col_d;
            dst_vld_q  <= dst_vld_d;
            dst_last_q <= dst_last_d;
            dst_ch_q   <= dst_ch_d;
            dst_row_q  <= dst_row_d;
            dst_col_q  <= dst_col_d;
            dst_dat_q  <= dst_dat_d;
        end
    end

    assign dst_wr_en   = dst_vld_q;
    assign dst_ch      = dst_ch_q;
    assign dst_row     = dst_row_q;
    assign dst_col     = dst_col_q;
    assign dst_wr_data = dst_dat_q;

endmodule

// File: tb/tb_layer_xfer_ctrl.sv
// Directed bench: small 2x3x3 instance for ordering, stalls, restarts and reset; default-size instance for the full map.
module tb_layer_xfer_ctrl;

    localparam int NCH  = 2;
    localparam int DM   = 3;
    localparam int NEL  = NCH * DM * DM;
    localparam int BDM  = 26;
    localparam int BNEL = 16 * BDM * BDM;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        dst_ready = 1'b1;
    logic        busy, done, next_start, src_rd_en, dst_wr_en;
    logic [15:0] src_ch, src_row, src_col, dst_ch, dst_row, dst_col;
    logic [63:0] src_rd_data = '0;
    logic [63:0] dst_wr_data;

    logic        b_start = 1'b0;
    logic        b_dst_ready = 1'b1;
    logic        b_busy, b_done, b_next_start, b_src_rd_en, b_dst_wr_en;
    logic [15:0] b_src_ch, b_src_row, b_src_col, b_dst_ch, b_dst_row, b_dst_col;
    logic [63:0] b_src_rd_data = '0;
    logic [63:0] b_dst_wr_data;

    int checks = 0;
    int errors = 0;

    layer_xfer_ctrl #(.NUM_CH(NCH), .DIM(DM), .IDX_W(16), .DATA_SIZE(64)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .next_start(next_start), .src_rd_en(src_rd_en), .src_ch(src_ch), .src_row(src_row),
        .src_col(src_col), .src_rd_data(src_rd_data), .dst_wr_en(dst_wr_en), .dst_ch(dst_ch),
        .dst_row(dst_row), .dst_col(dst_col), .dst_wr_data(dst_wr_data), .dst_ready(dst_ready)
    );

    layer_xfer_ctrl dut_big (
        .clk(clk), .reset_n(reset_n), .start(b_start), .busy(b_busy), .done(b_done),
        .next_start(b_next_start), .src_rd_en(b_src_rd_en), .src_ch(b_src_ch), .src_row(b_src_row),
        .src_col(b_src_col), .src_rd_data(b_src_rd_data), .dst_wr_en(b_dst_wr_en), .dst_ch(b_dst_ch),
        .dst_row(b_dst_row), .dst_col(b_dst_col), .dst_wr_data(b_dst_wr_data), .dst_ready(b_dst_ready)
    );

    // Source memories: word at (ch,row,col) is {16'h0, ch, row, col}, one-cycle read latency
    always @(posedge clk) if (src_rd_en) src_rd_data <= {16'h0, src_ch, src_row, src_col};
    always @(posedge clk) if (b_src_rd_en) b_src_rd_data <= {16'h0, b_src_ch, b_src_row, b_src_col};

    function automatic logic [63:0] exp_word(input int k, input int d);
        logic [15:0] c, r, l;
        c = 16'(k / (d * d));
        r = 16'((k / d) % d);
        l = 16'(k % d);
        return {16'h0, c, r, l};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; dst_ready = 1'b1; b_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (next_start !== 1'b0) begin errors++; $display("FAIL reset_next_start got %b exp 0", next_start); end
        checks++; if (src_rd_en !== 1'b0) begin errors++; $display("FAIL reset_src_rd_en got %b exp 0", src_rd_en); end
        checks++; if (dst_wr_en !== 1'b0) begin errors++; $display("FAIL reset_dst_wr_en got %b exp 0", dst_wr_en); end
        checks++; if ({src_ch, src_row, src_col} !== 48'h0) begin errors++; $display("FAIL reset_src_idx got %h exp 0", {src_ch, src_row, src_col}); end
        checks++; if ({dst_ch, dst_row, dst_col} !== 48'h0) begin errors++; $display("FAIL reset_dst_idx got %h exp 0", {dst_ch, dst_row, dst_col}); end
        checks++; if (dst_wr_data !== 64'h0) begin errors++; $display("FAIL reset_dst_data got %h exp 0", dst_wr_data); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_big_busy got %b exp 0", b_busy); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int k = 0, ndone = 0, dcyc = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start = (c == 0); dst_ready = 1'b1;
            #1;
            if (c == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
            end
            if (dst_wr_en && dst_ready) begin
                checks++;
                if ({16'h0, dst_ch, dst_row, dst_col} !== exp_word(k, DM) || dst_wr_data !== exp_word(k, DM)) begin
                    errors++;
                    $display("FAIL basic_wr #%0d got idx %h data %h exp %h", k, {dst_ch, dst_row, dst_col}, dst_wr_data, exp_word(k, DM));
                end
                k++;
            end
            if (done) begin
                ndone++; dcyc = c;
                checks++; if (next_start !== 1'b1) begin errors++; $display("FAIL basic_next_start got %b exp 1", next_start); end
            end
        end
        checks++; if (k != NEL) begin errors++; $display("FAIL basic_count got %0d exp %0d", k, NEL); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL basic_ndone got %0d exp 1", ndone); end
        checks++; if (dcyc != 21) begin errors++; $display("FAIL basic_done_cycle got %0d exp 21", dcyc); end
    endtask

    task automatic test_ready_toggle();
        int k = 0, ndone = 0, dcyc = -1, last_acc = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            start = (c == 0); dst_ready = ((c % 3) != 2);
            #1;
            if (dst_wr_en && dst_ready) begin
                checks++;
                if ({16'h0, dst_ch, dst_row, dst_col} !== exp_word(k, DM) || dst_wr_data !== exp_word(k, DM)) begin
                    errors++;
                    $display("FAIL toggle_wr #%0d got idx %h data %h exp %h", k, {dst_ch, dst_row, dst_col}, dst_wr_data, exp_word(k, DM));
                end
                k++; last_acc = c;
            end
            if (done) begin ndone++; dcyc = c; end
        end
        dst_ready = 1'b1;
        checks++; if (k != NEL) begin errors++; $display("FAIL toggle_count got %0d exp %0d", k, NEL); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL toggle_ndone got %0d exp 1", ndone); end
        checks++; if (dcyc != last_acc + 1) begin errors++; $display("FAIL toggle_done_cycle got %0d exp %0d", dcyc, last_acc + 1); end
    endtask

    task automatic test_stall();
        int k = 0, ndone = 0, dcyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = (c == 0); dst_ready = !(c >= 3 && c <= 7);
            #1;
            if (c >= 3 && c <= 7) begin
                checks++;
                if (dst_wr_en !== 1'b1 || src_rd_en !== 1'b0 || {16'h0, dst_ch, dst_row, dst_col} !== exp_word(0, DM)
                    || dst_wr_data !== exp_word(0, DM)) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d got wr %b rd %b idx %h data %h exp wr 1 rd 0 %h",
                             c, dst_wr_en, src_rd_en, {dst_ch, dst_row, dst_col}, dst_wr_data, exp_word(0, DM));
                end
            end
            if (c == 9) begin
                checks++;
                if (dst_wr_en !== 1'b1 || {16'h0, dst_ch, dst_row, dst_col} !== exp_word(1, DM)) begin
                    errors++;
                    $display("FAIL stall_resume got wr %b idx %h exp wr 1 %h", dst_wr_en, {dst_ch, dst_row, dst_col}, exp_word(1, DM));
                end
            end
            if (dst_wr_en && dst_ready) begin
                checks++;
                if ({16'h0, dst_ch, dst_row, dst_col} !== exp_word(k, DM) || dst_wr_data !== exp_word(k, DM)) begin
                    errors++;
                    $display("FAIL stall_wr #%0d got idx %h data %h exp %h", k, {dst_ch, dst_row, dst_col}, dst_wr_data, exp_word(k, DM));
                end
                k++;
            end
            if (done) begin ndone++; dcyc = c; end
        end
        dst_ready = 1'b1;
        checks++; if (k != NEL) begin errors++; $display("FAIL stall_count got %0d exp %0d", k, NEL); end
        checks++; if (ndone != 1 || dcyc != 26) begin errors++; $display("FAIL stall_done got n=%0d cyc=%0d exp n=1 cyc=26", ndone, dcyc); end
    endtask

    task automatic test_restart();
        int k = 0, ndone = 0, dcyc = -1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            start = (c == 0 || c == 5 || c == 21); dst_ready = 1'b1;
            #1;
            if (c == 23) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_idle got busy %b exp 0", busy); end
            end
            if (dst_wr_en && dst_ready) k++;
            if (done) begin ndone++; dcyc = c; end
        end
        start = 1'b0;
        checks++; if (k != NEL) begin errors++; $display("FAIL restart_count got %0d exp %0d", k, NEL); end
        checks++; if (ndone != 1 || dcyc != 21) begin errors++; $display("FAIL restart_done got n=%0d cyc=%0d exp n=1 cyc=21", ndone, dcyc); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start = (c == 0); dst_ready = 1'b1; reset_n = (c != 10);
            #1;
            if (c == 11) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || next_start !== 1'b0 || src_rd_en !== 1'b0 || dst_wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_ctrl got busy %b done %b ns %b rd %b wr %b exp all 0", busy, done, next_start, src_rd_en, dst_wr_en);
                end
                checks++;
                if ({src_ch, src_row, src_col, dst_ch, dst_row, dst_col} !== 96'h0 || dst_wr_data !== 64'h0) begin
                    errors++;
                    $display("FAIL midreset_data got src %h dst %h data %h exp 0",
                             {src_ch, src_row, src_col}, {dst_ch, dst_row, dst_col}, dst_wr_data);
                end
            end
            if (done || next_start) ndone++;
        end
        reset_n = 1'b1;
        checks++; if (ndone != 0) begin errors++; $display("FAIL midreset_done got %0d exp 0", ndone); end
    endtask

    task automatic test_big();
        int k = 0, oerr = 0, ndone = 0, dcyc = -1;
        logic [63:0] last_idx = '0;
        for (int c = 0; c < BNEL + 12; c++) begin
            @(negedge clk);
            b_start = (c == 0);
            #1;
            if (b_dst_wr_en && b_dst_ready) begin
                if ({16'h0, b_dst_ch, b_dst_row, b_dst_col} !== exp_word(k, BDM) || b_dst_wr_data !== exp_word(k, BDM)) oerr++;
                last_idx = {16'h0, b_dst_ch, b_dst_row, b_dst_col};
                k++;
            end
            if (b_done) begin ndone++; dcyc = c; end
        end
        checks++; if (k != BNEL) begin errors++; $display("FAIL big_count got %0d exp %0d", k, BNEL); end
        checks++; if (oerr != 0) begin errors++; $display("FAIL big_order got %0d bad writes exp 0", oerr); end
        checks++; if (last_idx !== 64'h0000_000f_0019_0019) begin errors++; $display("FAIL big_last got %h exp 0000000f00190019", last_idx); end
        checks++; if (ndone != 1 || dcyc != BNEL + 3) begin errors++; $display("FAIL big_done got n=%0d cyc=%0d exp n=1 cyc=%0d", ndone, dcyc, BNEL + 3); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_toggle();
        test_stall();
        test_restart();
        test_reset_mid();
        test_basic();
        test_big();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_xfer_ctrl.md
LAYER_XFER_CTRL -- requirements
Module: layer_xfer_ctrl

Interface
REQ-001 Parameter NUM_CH, default 16: channels in the transferred feature map.
REQ-002 Parameter DIM, default 26: row and column extent of the square feature map.
REQ-003 Parameter IDX_W, default 16: width of each index field.
REQ-004 Parameter DATA_SIZE, default 64: element width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  reset; synchronous, active-low.
REQ-007 start  in  1  request one full transfer; sampled only in IDLE.
REQ-008 busy  out  1  high in any state other than IDLE.
REQ-009 done  out  1  one-cycle pulse when the transfer completes.
REQ-010 next_start  out  1  one-cycle pulse, coincident with done, that starts the next layer's compute.
REQ-011 src_rd_en  out  1  read strobe to the source (layer output) memory.
REQ-012 src_ch, src_row, src_col  out  IDX_W each  read index.
REQ-013 src_rd_data  in  DATA_SIZE  read data, valid the cycle after src_rd_en; it is held stable while src_rd_en=0.
REQ-014 dst_wr_en  out  1  write valid to the destination (next-layer input) memory ("wantwrite").
REQ-015 dst_ch, dst_row, dst_col  out  IDX_W each  write index.
REQ-016 dst_wr_data  out  DATA_SIZE  write data.
REQ-017 dst_ready  in  1  destination accepts; a write transfers when dst_wr_en && dst_ready.

Function
REQ-018 Reset values: busy, done, next_start, src_rd_en and dst_wr_en are 0; all indices and dst_wr_data are 0.
REQ-019 The state machine has four states: IDLE, READ, DRAIN and FINISH.
REQ-020 IDLE->READ when start=1. Start is ignored in every other state.
REQ-021 Read order: col increments fastest, then row, then ch. col wraps from DIM-1 to 0 and increments row. row wraps from DIM-1 to 0 and increments ch.
REQ-022 The pipeline has two stages. Stage P1 holds the read-in-flight valid bit and its index. The output stage holds dst_wr_en, the dst index and dst_wr_data.
REQ-023 stall = dst_wr_en && !dst_ready. When stall=0, the output stage loads P1, capturing src_rd_data, and P1 loads the current issue.
REQ-024 src_rd_en = (state==READ) && !stall. When stall=1 both stages hold their contents and no index advances.
REQ-025 Issuing the element at (NUM_CH-1, DIM-1, DIM-1) causes READ->DRAIN.
REQ-026 DRAIN->FINISH on the cycle in which the last element is accepted.
REQ-027 FINISH lasts one cycle: done=1 and next_start=1, read and write indices are cleared, then FINISH->IDLE.
REQ-028 The output sequence contains exactly NUM_CH*DIM*DIM writes, with no duplicates and no gaps. dst index equals the src index issued two advancing cycles earlier.
REQ-029 Throughput is one element per cycle while dst_ready=1.
REQ-030 With dst_ready held at 1, done asserts NUM_CH*DIM*DIM+3 cycles after the cycle in which start is sampled.
REQ-031 dst_ready may toggle on any cycle, including the first and last element, without loss or repetition.
REQ-032 A start asserted together with done is ignored.

Reset
REQ-033 reset_n=0 at any clock edge, including mid-transfer, forces IDLE and the REQ-018 values on the next cycle. No done or next_start is generated for an aborted transfer.
REQ-034 reset_n has priority over all other inputs.

Structure
REQ-035 Shared package layer_pkg holds DATA_SIZE, IDX_W, per-layer NUM_CH/DIM constants and the state enumeration.
REQ-036 The three-level wrapping index counter is a separate sub-module, idx_counter3d, with inputs inc and clr and outputs ch, row, col and last.

Verification
REQ-037 NUM_CH=2, DIM=3, dst_ready=1, src_rd_data={ch,row,col} pattern; start pulse at cycle 0 -> 18 writes, in order (0,0,0) through (1,2,2), each with matching data; done and next_start high only in cycle 21.
REQ-038 Same configuration with dst_ready low on every third cycle -> still exactly 18 ordered writes with correct data; done one cycle after the 18th acceptance.
REQ-039 dst_ready=0 from the first dst_wr_en for 5 cycles -> dst_wr_en, dst index and data stay stable; src_rd_en=0 throughout; the sequence resumes at (0,0,1).
REQ-040 reset_n=0 at cycle 10 of the transfer -> all outputs zero at cycle 11; no done; a new start then gives a complete 18-element transfer starting at (0,0,0).
REQ-041 start re-pulsed at cycles 5 and 21 -> no effect, exactly one done.
REQ-042 Defaults NUM_CH=16, DIM=26, dst_ready=1 -> 10816 writes; last write at (15,25,25); done at cycle 10819.
